muldiv_unit: RTL and testbench

Iterative multiply/divide unit of the MIPS execute stage; it produces the 64-bit {HI,LO} value and per-half write enables consumed by the HI/LO register file. It computes MULT/MULTU in one cycle and DIV/DIVU with a 32-iteration restoring divider. While a division is in progress it drives a busy stall to the pipeline, and a flush from the hazard unit cancels it.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_unit_div_step.sv | 30 +++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : operation encodings, FSM states and constants for muldiv_unit
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
// ============================================================================
// div_step : one combinational restoring-division iteration (32-bit)
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step (
   input  logic [31:0] rem_i,
   input  logic        dvd_bit_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic        q_bit_o
);

   logic [32:0] w_shifted;
   logic        w_ge;
   logic [31:0] w_diff;

   assign w_shifted = {rem_i, dvd_bit_i};
   assign w_ge      = (w_shifted >= {1'b0, divisor_i});
   // When the trial subtract succeeds the true difference is below the divisor,
   // so the low 32 bits carry the whole result.
   assign w_diff    = w_shifted[31:0] - divisor_i;

   assign rem_o   = w_ge ? w_diff : w_shifted[31:0];
   assign q_bit_o = w_ge;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : single-cycle MULT/MULTU, 32-step restoring DIV/DIVU for HI/LO.
// Optional macro MULDIV_EARLY_OUT_EN: skip iterations when |a| < |b|, b != 0.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [63:0] result,
   output logic [1:0]  hilo_we
);

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        neg_quo_q;
   logic        neg_rem_q;
   logic        dz_q;
   logic        busy_q;
   logic        done_q;
   logic [1:0]  hilo_we_q;
   logic [63:0] result_q;

   logic        w_sgn;
   logic        w_is_div;
   logic [63:0] w_prod;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] rem_d;
   logic        qbit_d;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   assign w_sgn    = (op == OP_MULT) || (op == OP_DIV);
   assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);

   // Product modulo 2^64 of the sign/zero-extended operands is the exact
   // 64-bit product for both signed and unsigned forms.
   assign w_prod = {{32{w_sgn & a[31]}}, a} * {{32{w_sgn & b[31]}}, b};

   assign w_abs_a = (w_sgn && a[31]) ? (32'd0 - a) : a;
   assign w_abs_b = (w_sgn && b[31]) ? (32'd0 - b) : b;

   div_step u_div_step (
      .rem_i     (rem_q),
      .dvd_bit_i (quo_q[31]),
      .divisor_i (dvs_q),
      .rem_o     (rem_d),
      .q_bit_o   (qbit_d)
   );

   assign w_quo_fix = dz_q      ? 32'hFFFF_FFFF :
                      neg_quo_q ? (32'd0 - quo_q) : quo_q;
   assign w_rem_fix = neg_rem_q ? (32'd0 - rem_q) : rem_q;

`ifdef MULDIV_EARLY_OUT_EN
   logic w_early;
   assign w_early = (b != 32'd0) && (w_abs_a < w_abs_b);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_q     <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hilo_we_q <= 2'b00;
         result_q  <= 64'd0;
      end else if (flush) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hilo_we_q <= 2'b00;
      end else begin
         done_q    <= 1'b0;
         hilo_we_q <= 2'b00;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start && !w_is_div) begin
                  result_q  <= w_prod;
                  done_q    <= 1'b1;
                  hilo_we_q <= 2'b11;
                  busy_q    <= 1'b0;
                  state_q   <= ST_DONE;
               end else if (start) begin
                  rem_q     <= 32'd0;
                  quo_q     <= w_abs_a;
                  dvs_q     <= w_abs_b;
                  neg_quo_q <= w_sgn & (a[31] ^ b[31]);
                  neg_rem_q <= w_sgn & a[31];
                  dz_q      <= (b == 32'd0);
                  cnt_q     <= 5'd0;
                  busy_q    <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                  if (w_early) begin
                     rem_q   <= w_abs_a;
                     quo_q   <= 32'd0;
                     state_q <= ST_FIX;
                  end else begin
                     state_q <= ST_DIV;
                  end
`else
                  state_q   <= ST_DIV;
`endif
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_DIV: begin
               // Dividend shifts out of quo_q's MSB as quotient bits shift in.
               rem_q <= rem_d;
               quo_q <= {quo_q[30:0], qbit_d};
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(DIV_ITERS - 1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               result_q  <= {w_rem_fix, w_quo_fix};
               done_q    <= 1'b1;
               hilo_we_q <= 2'b11;
               busy_q    <= 1'b0;
               state_q   <= ST_DONE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
   assign hilo_we = hilo_we_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : table-driven directed checks for muldiv_unit
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int LAT_DIV = 34;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_EO = 2;
`else
   localparam int LAT_EO = 34;
`endif
   localparam int NVEC = 14;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      int          lat;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic [1:0]  hilo_we;

   int n_chk  = 0;
   int n_fail = 0;

   muldiv_unit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .hilo_we (hilo_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Launches one op and waits (bounded) for done; lat = -1 on timeout.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt,
                         output logic [63:0] res, output logic [1:0] we);
      bit found;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bcnt = 0; res = '0; we = '0; found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         lat++;
         if (busy) bcnt++;
         if (done) begin
            res = result; we = hilo_we; found = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!found) lat = -1;
   endtask

   // Start a DIVU 1000/7 and leave it after 10 iterations.
   task automatic start_div_mid();
      @(negedge clk);
      op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   vec_t vecs [NVEC];

   initial begin
      int          lat, bcnt, dcnt;
      logic [63:0] res;
      logic [1:0]  we;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, 1};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000003, 64'h00000002_FFFFFFFD, 1};
      vecs[2]  = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 64'h00000000_0000000F, 1};
      vecs[3]  = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1};
      vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, LAT_DIV};
      vecs[5]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, LAT_DIV};
      vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, LAT_DIV};
      vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, LAT_DIV};
      vecs[8]  = '{OP_DIV,   32'hFFFFFF9C, 32'h00000000, 64'hFFFFFF9C_FFFFFFFF, LAT_DIV};
      vecs[9]  = '{OP_DIVU,  32'd1000,     32'd7,        64'h00000006_0000008E, LAT_DIV};
      vecs[10] = '{OP_DIVU,  32'd3,        32'd5,        64'h00000003_00000000, LAT_EO};
      vecs[11] = '{OP_DIV,   32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFD_00000000, LAT_EO};
      vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, LAT_DIV};
      vecs[13] = '{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, LAT_EO};

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",   64'(busy),    64'd0);
      chk("reset_done",   64'(done),    64'd0);
      chk("reset_result", result,       64'd0);
      chk("reset_we",     64'(hilo_we), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, res, we);
         chk($sformatf("v%0d_result", i), res, vecs[i].res);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat - 1));
         chk($sformatf("v%0d_hilo_we", i), 64'(we), 64'd3);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), 64'({done, hilo_we}), 64'd0);
         chk($sformatf("v%0d_result_hold", i), result, vecs[i].res);
      end

      // Back-to-back: each start lands in the previous DONE cycle.
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'd3, lat, bcnt, res, we);
      chk("b2b_multu", res, 64'h00000002_FFFFFFFD);
      run_op(OP_DIVU, 32'd1000, 32'd7, lat, bcnt, res, we);
      chk("b2b_divu_result", res, 64'h00000006_0000008E);
      chk("b2b_divu_latency", 64'(lat), 64'(LAT_DIV));
      run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, lat, bcnt, res, we);
      chk("b2b_mult_result", res, 64'hFFFFFFFF_FFFFFFFE);
      chk("b2b_mult_latency", 64'(lat), 64'd1);
      @(posedge clk); #1;

      // Flush mid-division.
      start_div_mid();
      chk("flush_pre_busy", 64'(busy), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_done_we", 64'({done, hilo_we}), 64'd0);
      chk("flush_result_hold", result, 64'hFFFFFFFF_FFFFFFFE);
      @(negedge clk);
      flush = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy || hilo_we != 2'b00) dcnt++;
      end
      chk("flush_no_activity", 64'(dcnt), 64'd0);
      run_op(OP_DIVU, 32'd1000, 32'd7, lat, bcnt, res, we);
      chk("restart_result", res, 64'h00000006_0000008E);
      chk("restart_latency", 64'(lat), 64'(LAT_DIV));
      @(posedge clk); #1;

      // Flush wins over a simultaneous start.
      @(negedge clk);
      op = OP_DIVU; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_prio_busy", 64'(busy), 64'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) dcnt++;
      end
      chk("flush_prio_no_activity", 64'(dcnt), 64'd0);

      // Reset mid-division clears everything including result.
      start_div_mid();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_busy",   64'(busy),    64'd0);
      chk("rst_mid_done",   64'(done),    64'd0);
      chk("rst_mid_we",     64'(hilo_we), 64'd0);
      chk("rst_mid_result", result,       64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_MULT, 32'd7, 32'd6, lat, bcnt, res, we);
      chk("post_rst_mult", res, 64'd42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
